gm_move_entry: RTL and testbench
================================

GM_MOVE_ENTRY -- requirements
Module: gm_move_entry

Interface
REQ-001 SHALL have parameter CMD_W, default 2: command code width.
REQ-002 SHALL have parameter COORD_W, default 4: width of one grid coordinate.
REQ-003 SHALL have parameter GRID_MAX, default 13: largest legal coordinate value (14x14 map).
REQ-004 SHALL have parameter NUM_PTS, default 2: coordinate pairs per move; NUM_FIELDS = 1 + 2*NUM_PTS.
REQ-005 SHALL have parameter DB_CYCLES, default 4: cycles a key must stay stable to count as a press.
REQ-006 SHALL have ports:
- CLOCK_50  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  level; the gamemaster's turn is open.
- abort  in  1  one-cycle discard request.
- sw  in  max(CMD_W,COORD_W)  switch value.
- enter_n  in  1  raw active-low key, commit field.
- back_n  in  1  raw active-low key, re-enter previous field.
- cmd  out  CMD_W  captured command.
- pts  out  2*NUM_PTS*COORD_W  packed {x,y} pairs; pair 0 in the LSBs, x below y.
- field_idx  out  clog2(NUM_FIELDS+1)  field now being entered.
- disp_val  out  COORD_W  last committed value, zero-extended.
- busy  out  1  high whenever not IDLE.
- err  out  1  one-cycle pulse on a rejected entry.
- move_valid  out  1  move offered.
- move_ready  in  1  consumer accepts.
- done  out  1  one-cycle pulse on transfer.

Function
REQ-007 SHALL pass enter_n and back_n through a 2-flop synchroniser, then a debouncer; a press event = one cycle, raised when a synchronised key has been low for DB_CYCLES consecutive cycles after having been high; one event per press.
REQ-008 SHALL implement states IDLE, CAPTURE, OFFER.
REQ-009 IDLE: start=1 -> CAPTURE, field_idx=0; cmd and pts cleared to 0 on entry.
REQ-010 CAPTURE, enter event, field_idx=0: cmd <= sw[CMD_W-1:0]; if value==0 (pass move) -> OFFER with pts=0, else field_idx=1.
REQ-011 CAPTURE, enter event, field_idx=k>0: v=sw[COORD_W-1:0]; v>GRID_MAX -> err pulse, no write, idx unchanged; else write field k (k odd = x, even = y of pair (k-1)/2), disp_val<=v, then idx+1, or -> OFFER if k=NUM_FIELDS-1.
REQ-012 CAPTURE, back event: idx>0 -> idx-1, earlier values retained until overwritten; idx=0 -> ignored.
REQ-013 Enter and back events in the same cycle: enter wins, back dropped.
REQ-014 OFFER: move_valid=1, cmd/pts stable; move_valid&move_ready -> done pulse next cycle, -> IDLE; back event in OFFER -> CAPTURE at last field (pass move: field 0).
REQ-015 abort in CAPTURE or OFFER -> IDLE in one cycle, move_valid dropped, no done; abort beats every other event.
REQ-016 start deasserting during CAPTURE/OFFER SHALL be ignored; only abort or transfer ends a move.
REQ-017 Key events while in IDLE SHALL be discarded.
REQ-018 A key held at reset release SHALL not produce an event until released and re-pressed.

Reset
REQ-019 reset=1 SHALL force, asynchronously: state IDLE, outputs cmd, pts, field_idx, disp_val, err, move_valid, done, busy = 0; debounce counters 0; synchroniser flops = 1 (released).

Verification
REQ-020 Full move: start=1; enter with sw=1,3,4,5,6 -> OFFER, cmd=1, pts=16'h6543, move_valid=1; move_ready=1 -> done 1 cycle, busy=0.
REQ-021 Range reject: field 1, sw=14 -> err pulse, field_idx stays 1; sw=13 -> accepted, field_idx=2.
REQ-022 Bounce: enter_n low for 3 cycles then high -> no event; low 4+ cycles -> exactly one event.
REQ-023 Back/simultaneous: at field 3, back -> idx 2; enter and back same cycle at idx 2 -> idx 3, sw value stored.
REQ-024 Pass move: enter with sw=0 at field 0 -> OFFER directly, pts=0; abort while move_valid=1 -> IDLE, no done.
REQ-025 Reset mid-OFFER: reset=1 asynchronously clears move_valid; held key after reset release -> no event until re-pressed.

Source files
------------

// File: rtl/gm_move_entry.sv
// rtl/gm_move_entry.sv - Gamemaster move entry: debounced keys, field capture FSM, valid/ready offer
//
// Ports:
//   CLOCK_50    sole clock, rising edge
//   reset       asynchronous, active-high
//   start       level, gamemaster turn open (only sampled in IDLE)
//   abort       one-cycle discard request, highest priority
//   sw          switch value; low CMD_W bits for the command, low COORD_W bits for coordinates
//   enter_n     raw active-low key, commit current field
//   back_n      raw active-low key, step back one field
//   cmd         captured command
//   pts         packed coordinates, field k lives at bits [(k-1)*COORD_W +: COORD_W]
//   field_idx   field currently being entered (0 = command)
//   disp_val    last committed coordinate
//   busy        high whenever not IDLE
//   err         one-cycle pulse on an out-of-range coordinate
//   move_valid  move is being offered
//   move_ready  consumer accepts the offered move
//   done        one-cycle pulse the cycle after a transfer
module gm_move_entry #(
    parameter int CMD_W     = 2,
    parameter int COORD_W   = 4,
    parameter int GRID_MAX  = 13,
    parameter int NUM_PTS   = 2,
    parameter int DB_CYCLES = 4
) (
    input  logic                                        CLOCK_50,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic                                        abort,
    input  logic [((CMD_W > COORD_W) ? CMD_W : COORD_W)-1:0] sw,
    input  logic                                        enter_n,
    input  logic                                        back_n,
    output logic [CMD_W-1:0]                            cmd,
    output logic [2*NUM_PTS*COORD_W-1:0]                pts,
    output logic [$clog2(2*NUM_PTS+2)-1:0]              field_idx,
    output logic [COORD_W-1:0]                          disp_val,
    output logic                                        busy,
    output logic                                        err,
    output logic                                        move_valid,
    input  logic                                        move_ready,
    output logic                                        done
);

    localparam int NUM_FIELDS = 1 + 2*NUM_PTS;
    localparam int FI_W       = $clog2(NUM_FIELDS + 1);
    localparam int CNT_W      = $clog2(DB_CYCLES + 1);
    localparam logic [FI_W-1:0]  LAST_IDX = FI_W'(NUM_FIELDS - 1);
    localparam logic [CNT_W-1:0] CNT_HIT  = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_OFFER} state_t;

    // ---------------- key synchronisers and debouncers ----------------
    // Index 0 = enter, index 1 = back.
    logic [1:0]       w_raw;
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_armed;
    logic [1:0]       r_warm;
    logic [CNT_W-1:0] r_db_cnt [2];
    logic [1:0]       w_evt;

    assign w_raw = {back_n, enter_n};

    always_comb begin
        w_evt = '0;
        for (int k = 0; k < 2; k++)
            w_evt[k] = r_armed[k] && !r_sync2[k] && (r_db_cnt[k] == CNT_HIT);
    end

    // The synchroniser flops reset to "released", so a key held through reset
    // would look high for two cycles afterwards. r_warm keeps arming disabled
    // until real key samples have reached r_sync2.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_sync1     <= '1;
            r_sync2     <= '1;
            r_armed     <= '0;
            r_warm      <= '0;
            r_db_cnt[0] <= '0;
            r_db_cnt[1] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_warm  <= {r_warm[0], 1'b1};
            for (int k = 0; k < 2; k++) begin
                if (r_sync2[k]) begin
                    r_db_cnt[k] <= '0;
                    if (r_warm[1])
                        r_armed[k] <= 1'b1;
                end else if (r_armed[k]) begin
                    if (w_evt[k])
                        r_armed[k] <= 1'b0;
                    else
                        r_db_cnt[k] <= r_db_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    // Enter wins over a simultaneous back.
    logic w_enter;
    logic w_back;
    assign w_enter = w_evt[0];
    assign w_back  = w_evt[1] && !w_evt[0];

    // ---------------- move capture FSM ----------------
    state_t                     r_state;
    state_t                     w_next;
    logic [CMD_W-1:0]           r_cmd;
    logic [2*NUM_PTS*COORD_W-1:0] r_pts;
    logic [FI_W-1:0]            r_idx;
    logic [COORD_W-1:0]         r_disp;
    logic                       r_err;
    logic                       r_done;

    logic [CMD_W-1:0]   w_cmd_in;
    logic [COORD_W-1:0] w_coord;
    logic               w_in_range;

    assign w_cmd_in   = sw[CMD_W-1:0];
    assign w_coord    = sw[COORD_W-1:0];
    assign w_in_range = (int'(w_coord) <= GRID_MAX);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start)
                    w_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (abort)
                    w_next = S_IDLE;
                else if (w_enter) begin
                    if (r_idx == '0) begin
                        if (w_cmd_in == '0)
                            w_next = S_OFFER;
                    end else if (w_in_range && r_idx == LAST_IDX)
                        w_next = S_OFFER;
                end
            end
            S_OFFER: begin
                if (abort || move_ready)
                    w_next = S_IDLE;
                else if (w_back)
                    w_next = S_CAPTURE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Field index stays put on entering OFFER, so a back from OFFER lands on
    // the last field (or field 0 for a pass move) with no extra bookkeeping.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_cmd  <= '0;
            r_pts  <= '0;
            r_idx  <= '0;
            r_disp <= '0;
            r_err  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_err  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cmd <= '0;
                        r_pts <= '0;
                        r_idx <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (abort)
                        r_idx <= '0;
                    else if (w_enter) begin
                        if (r_idx == '0) begin
                            r_cmd <= w_cmd_in;
                            if (w_cmd_in == '0)
                                r_pts <= '0;
                            else
                                r_idx <= FI_W'(1);
                        end else if (!w_in_range) begin
                            r_err <= 1'b1;
                        end else begin
                            for (int f = 1; f < NUM_FIELDS; f++)
                                if (r_idx == FI_W'(f))
                                    r_pts[(f-1)*COORD_W +: COORD_W] <= w_coord;
                            r_disp <= w_coord;
                            if (r_idx != LAST_IDX)
                                r_idx <= r_idx + FI_W'(1);
                        end
                    end else if (w_back && r_idx != '0) begin
                        r_idx <= r_idx - FI_W'(1);
                    end
                end
                S_OFFER: begin
                    if (abort)
                        r_idx <= '0;
                    else if (move_ready) begin
                        r_done <= 1'b1;
                        r_idx  <= '0;
                    end
                end
                default: r_idx <= '0;
            endcase
        end
    end

    assign cmd        = r_cmd;
    assign pts        = r_pts;
    assign field_idx  = r_idx;
    assign disp_val   = r_disp;
    assign err        = r_err;
    assign done       = r_done;
    assign busy       = (r_state != S_IDLE);
    assign move_valid = (r_state == S_OFFER);

endmodule

// File: tb/tb_gm_move_entry.sv
// tb/tb_gm_move_entry.sv - Self-checking bench for gm_move_entry with a transaction-level move model
module tb_gm_move_entry;

    localparam int CMD_W    = 2;
    localparam int COORD_W  = 4;
    localparam int GRID_MAX = 13;
    localparam int NUM_PTS  = 2;
    localparam int DB       = 4;
    localparam int NF       = 1 + 2*NUM_PTS;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [3:0]  sw;
    logic        enter_n;
    logic        back_n;
    logic [1:0]  cmd;
    logic [15:0] pts;
    logic [2:0]  field_idx;
    logic [3:0]  disp_val;
    logic        busy;
    logic        err;
    logic        move_valid;
    logic        move_ready;
    logic        done;

    gm_move_entry #(
        .CMD_W(CMD_W), .COORD_W(COORD_W), .GRID_MAX(GRID_MAX),
        .NUM_PTS(NUM_PTS), .DB_CYCLES(DB)
    ) dut (
        .CLOCK_50(clk), .reset(reset), .start(start), .abort(abort), .sw(sw),
        .enter_n(enter_n), .back_n(back_n), .cmd(cmd), .pts(pts),
        .field_idx(field_idx), .disp_val(disp_val), .busy(busy), .err(err),
        .move_valid(move_valid), .move_ready(move_ready), .done(done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int err_seen = 0;
    int done_seen = 0;

    always @(negedge clk) begin
        if (err === 1'b1)  err_seen++;
        if (done === 1'b1) done_seen++;
    end

    // Behavioural model: one update per completed key press / handshake.
    bit m_busy, m_offer;
    int m_idx, m_cmd, m_disp, exp_err, exp_done;
    int m_f [NF];

    function automatic logic [31:0] model_pts();
        logic [31:0] acc;
        acc = 0;
        for (int k = 1; k < NF; k++)
            acc = acc + 32'(m_f[k] * (1 << (COORD_W*(k-1))));
        return acc;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_offer = 0; m_idx = 0; m_cmd = 0; m_disp = 0;
        for (int k = 0; k < NF; k++) m_f[k] = 0;
    endtask

    task automatic model_start();
        if (!m_busy) begin
            m_busy = 1; m_offer = 0; m_idx = 0; m_cmd = 0;
            for (int k = 0; k < NF; k++) m_f[k] = 0;
        end
    endtask

    task automatic model_key(input bit ent, input bit bk, input int v);
        if (!m_busy) return;
        if (ent) begin
            if (m_offer) return;
            if (m_idx == 0) begin
                m_cmd = v % (1 << CMD_W);
                if (m_cmd == 0) begin
                    for (int k = 0; k < NF; k++) m_f[k] = 0;
                    m_offer = 1;
                end else
                    m_idx = 1;
            end else if (v > GRID_MAX) begin
                exp_err++;
            end else begin
                m_f[m_idx] = v;
                m_disp = v;
                if (m_idx == NF-1) m_offer = 1;
                else m_idx++;
            end
        end else if (bk) begin
            if (m_offer) begin
                m_offer = 0;
                m_idx = (m_cmd == 0) ? 0 : NF-1;
            end else if (m_idx > 0)
                m_idx--;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".cmd"}, 32'(cmd), 32'(m_cmd));
        check({tag, ".pts"}, 32'(pts), model_pts());
        check({tag, ".move_valid"}, 32'(move_valid), 32'(m_offer));
        check({tag, ".busy"}, 32'(busy), 32'(m_busy));
        check({tag, ".disp_val"}, 32'(disp_val), 32'(m_disp));
        check({tag, ".err_pulses"}, 32'(err_seen), 32'(exp_err));
        check({tag, ".done_pulses"}, 32'(done_seen), 32'(exp_done));
        if (m_busy)
            check({tag, ".field_idx"}, 32'(field_idx), 32'(m_idx));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic key(input string tag, input bit ent, input bit bk, input int v, input int hold);
        sw = 4'(v);
        enter_n = !ent;
        back_n = !bk;
        tick(hold);
        enter_n = 1'b1;
        back_n = 1'b1;
        tick(5);
        if (hold >= DB) model_key(ent, bk, v);
        check_all(tag);
    endtask

    task automatic do_start(input string tag);
        start = 1'b1; tick(1); start = 1'b0; tick(1);
        model_start();
        check_all(tag);
    endtask

    task automatic do_ready(input string tag);
        move_ready = 1'b1; tick(1); move_ready = 1'b0; tick(2);
        if (m_offer) begin
            m_offer = 0; m_busy = 0; m_idx = 0; exp_done++;
        end
        check_all(tag);
    endtask

    task automatic do_abort(input string tag);
        abort = 1'b1; tick(1); abort = 1'b0; tick(2);
        if (m_busy) begin
            m_busy = 0; m_offer = 0; m_idx = 0;
        end
        check_all(tag);
    endtask

    initial begin
        int op, v;
        reset = 1'b1; start = 1'b0; abort = 1'b0; sw = '0;
        enter_n = 1'b1; back_n = 1'b1; move_ready = 1'b0;
        exp_err = 0; exp_done = 0;
        model_reset();
        tick(3);
        check_all("reset");
        check("reset.field_idx", 32'(field_idx), 32'd0);
        reset = 1'b0;
        tick(3);

        // Full move
        do_start("full.start");
        key("full.cmd", 1, 0, 1, 8);
        key("full.x0", 1, 0, 3, 8);
        key("full.y0", 1, 0, 4, 8);
        key("full.x1", 1, 0, 5, 8);
        key("full.y1", 1, 0, 6, 8);
        check("full.pts_literal", 32'(pts), 32'h6543);
        do_ready("full.ready");

        // Range reject, back, simultaneous keys, bounce
        do_start("range.start");
        key("range.cmd", 1, 0, 2, 8);
        key("range.reject14", 1, 0, 14, 8);
        key("range.accept13", 1, 0, 13, 8);
        key("back.f2", 1, 0, 7, 8);
        key("back.step", 0, 1, 0, 8);
        key("both.enter_wins", 1, 1, 9, 8);
        key("bounce.3cyc", 1, 0, 2, 3);
        key("bounce.4cyc", 1, 0, 2, 4);
        do_abort("range.abort");

        // Pass move then abort while offering
        do_start("pass.start");
        key("pass.cmd0", 1, 0, 0, 8);
        do_abort("pass.abort");

        // Randomized sequence against the model
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 9);
            if (!m_busy && $urandom_range(0, 1) == 1) op = 0;
            if (m_offer && (op >= 1 && op <= 4 || op == 6)) op = 5;
            v = $urandom_range(0, 15);
            case (op)
                0:       do_start("rnd.start");
                1, 2, 3, 4: key("rnd.enter", 1, 0, v, 8);
                5:       key("rnd.back", 0, 1, v, 8);
                6:       key("rnd.both", 1, 1, v, 8);
                7:       key("rnd.bounce", 1, 0, v, 3);
                8:       do_ready("rnd.ready");
                default: do_abort("rnd.abort");
            endcase
        end
        do_abort("rnd.cleanup");

        // Asynchronous reset during OFFER, key held through reset
        do_start("arst.start");
        key("arst.cmd", 1, 0, 2, 8);
        key("arst.f1", 1, 0, 1, 8);
        key("arst.f2", 1, 0, 2, 8);
        key("arst.f3", 1, 0, 3, 8);
        key("arst.f4", 1, 0, 4, 8);
        @(posedge clk);
        #3;
        sw = 4'd1;
        enter_n = 1'b0;
        reset = 1'b1;
        #1;
        check("arst.move_valid_async", 32'(move_valid), 32'd0);
        check("arst.busy_async", 32'(busy), 32'd0);
        model_reset();
        tick(2);
        reset = 1'b0;
        start = 1'b1; tick(1); start = 1'b0;
        model_start();
        tick(12);
        check_all("arst.held_key");
        enter_n = 1'b1;
        tick(5);
        key("arst.repress", 1, 0, 2, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
